// File: rtl/stage_memory_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stage_memory_pkg : memory-stage op codes, exception codes, FSM type  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package stage_memory_pkg;

    localparam int MEM_OP_LEN   = 4;
    localparam int EXC_CODE_LEN = 5;

    localparam logic [MEM_OP_LEN-1:0] MEM_OP_NONE = 4'd0;
    localparam logic [MEM_OP_LEN-1:0] MEM_OP_LW   = 4'd1;
    localparam logic [MEM_OP_LEN-1:0] MEM_OP_LH   = 4'd2;
    localparam logic [MEM_OP_LEN-1:0] MEM_OP_LHU  = 4'd3;
    localparam logic [MEM_OP_LEN-1:0] MEM_OP_LB   = 4'd4;
    localparam logic [MEM_OP_LEN-1:0] MEM_OP_LBU  = 4'd5;
    localparam logic [MEM_OP_LEN-1:0] MEM_OP_SW   = 4'd6;
    localparam logic [MEM_OP_LEN-1:0] MEM_OP_SH   = 4'd7;
    localparam logic [MEM_OP_LEN-1:0] MEM_OP_SB   = 4'd8;

    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_NONE = 5'd0;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADEL = 5'd4;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADES = 5'd5;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_load(input logic [MEM_OP_LEN-1:0] op);
        return (op == MEM_OP_LW) || (op == MEM_OP_LH) || (op == MEM_OP_LHU) ||
               (op == MEM_OP_LB) || (op == MEM_OP_LBU);
    endfunction

    function automatic logic is_store(input logic [MEM_OP_LEN-1:0] op);
        return (op == MEM_OP_SW) || (op == MEM_OP_SH) || (op == MEM_OP_SB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_memory_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_align : byte-lane steering for stores and extension for loads    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_align
    import stage_memory_pkg::*;
(
    input  logic [MEM_OP_LEN-1:0] st_op,
    input  logic [1:0]            st_lane,
    input  logic [31:0]           store_data,
    output logic [3:0]            be,
    output logic [31:0]           wdata,
    input  logic [MEM_OP_LEN-1:0] ld_op,
    input  logic [1:0]            ld_lane,
    input  logic [31:0]           rdata,
    output logic [31:0]           load_data
);

    logic [31:0] w_shifted;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (st_op)
            MEM_OP_SH: begin
                be    = 4'b0011 << st_lane;
                wdata = {2{store_data[15:0]}};
            end
            MEM_OP_SB: begin
                be    = 4'b0001 << st_lane;
                wdata = {4{store_data[7:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    always_comb begin
        w_shifted = rdata >> {ld_lane, 3'b000};
        load_data = rdata;
        case (ld_op)
            MEM_OP_LH:  load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_OP_LHU: load_data = {16'h0000, w_shifted[15:0]};
            MEM_OP_LB:  load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_OP_LBU: load_data = {24'h000000, w_shifted[7:0]};
            default:    load_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stage_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stage_memory : pipeline memory stage, single-outstanding bus master  |
// | Option: MEM_BUS_TIMEOUT_EN adds a 15-cycle bus timeout (EXC DBE).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stage_memory
    import stage_memory_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             addr,
    input  logic [31:0]             store_data,
    input  logic [MEM_OP_LEN-1:0]   mem_op,
    input  logic [EXC_CODE_LEN-1:0] exc_in,
    input  logic                    int_req,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [31:0]             bus_addr,
    output logic [31:0]             bus_wdata,
    output logic [3:0]              bus_be,
    input  logic                    bus_ack,
    input  logic [31:0]             bus_rdata,
    output logic [31:0]             load_result,
    output logic                    mem_busy,
    output logic [EXC_CODE_LEN-1:0] exc
);

    mem_state_t              r_state;
    mem_state_t              w_next_state;
    logic [31:0]             r_bus_addr;
    logic [31:0]             r_bus_wdata;
    logic [3:0]              r_bus_be;
    logic                    r_bus_we;
    logic [MEM_OP_LEN-1:0]   r_op;
    logic [1:0]              r_lane;
    logic [31:0]             r_load_result;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata;
    logic [31:0]             w_load_data;
    logic                    w_is_load;
    logic                    w_is_store;
    logic                    w_misaligned;
    logic                    w_start;
    logic                    w_tmo_fire;
    logic                    w_tmo_flag;
    logic [EXC_CODE_LEN-1:0] w_local_exc;

    assign w_is_load    = is_load(mem_op);
    assign w_is_store   = is_store(mem_op);
    assign w_misaligned = (((mem_op == MEM_OP_LW) || (mem_op == MEM_OP_SW)) && (addr[1:0] != 2'b00)) ||
                          (((mem_op == MEM_OP_LH) || (mem_op == MEM_OP_LHU) || (mem_op == MEM_OP_SH)) && addr[0]);
    assign w_start      = (r_state == ST_IDLE) && (mem_op != MEM_OP_NONE) &&
                          (exc_in == EXC_CODE_NONE) && !int_req && !w_misaligned;

    mem_align u_align (
        .st_op      (mem_op),
        .st_lane    (addr[1:0]),
        .store_data (store_data),
        .be         (w_be),
        .wdata      (w_wdata),
        .ld_op      (r_op),
        .ld_lane    (r_lane),
        .rdata      (bus_rdata),
        .load_data  (w_load_data)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [3:0] c_TMO_LAST = 4'd14;
    logic [3:0] r_tmo_cnt;
    logic       r_timeout;

    assign w_tmo_fire = (r_state == ST_REQ) && !bus_ack && (r_tmo_cnt == c_TMO_LAST);
    assign w_tmo_flag = r_timeout;

    // Counts REQ cycles; the 15th un-acked one forces the FSM out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= 4'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo_fire;
            if (r_state == ST_REQ)
                r_tmo_cnt <= r_tmo_cnt + 4'd1;
            else
                r_tmo_cnt <= 4'd0;
        end
    end
`else
    assign w_tmo_fire = 1'b0;
    assign w_tmo_flag = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next_state = ST_REQ;
            ST_REQ:  if (bus_ack || w_tmo_fire) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_local_exc = EXC_CODE_NONE;
        if (w_misaligned && w_is_load)
            w_local_exc = EXC_CODE_ADEL;
        else if (w_misaligned && w_is_store)
            w_local_exc = EXC_CODE_ADES;
        else if ((r_state == ST_DONE) && w_tmo_flag)
            w_local_exc = EXC_CODE_DBE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_bus_addr    <= 32'h0;
            r_bus_wdata   <= 32'h0;
            r_bus_be      <= 4'h0;
            r_bus_we      <= 1'b0;
            r_op          <= MEM_OP_NONE;
            r_lane        <= 2'b00;
            r_load_result <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_bus_addr  <= {addr[31:2], 2'b00};
                r_bus_wdata <= w_wdata;
                r_bus_be    <= w_be;
                r_bus_we    <= w_is_store;
                r_op        <= mem_op;
                r_lane      <= addr[1:0];
            end
            if ((r_state == ST_REQ) && bus_ack && is_load(r_op))
                r_load_result <= w_load_data;
        end
    end

    assign bus_req     = (r_state == ST_REQ);
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign bus_be      = r_bus_be;
    assign load_result = r_load_result;
    assign mem_busy    = w_start || (r_state == ST_REQ);
    assign exc         = (exc_in != EXC_CODE_NONE) ? exc_in : w_local_exc;

endmodule
`default_nettype wire

// File: tb/tb_stage_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stage_memory : directed self-checking bench for stage_memory      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_stage_memory;
    import stage_memory_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [31:0]             addr = 32'h0;
    logic [31:0]             store_data = 32'h0;
    logic [MEM_OP_LEN-1:0]   mem_op = MEM_OP_NONE;
    logic [EXC_CODE_LEN-1:0] exc_in = 5'd0;
    logic                    int_req = 1'b0;
    logic                    bus_req;
    logic                    bus_we;
    logic [31:0]             bus_addr;
    logic [31:0]             bus_wdata;
    logic [3:0]              bus_be;
    logic                    bus_ack = 1'b0;
    logic [31:0]             bus_rdata = 32'h0;
    logic [31:0]             load_result;
    logic                    mem_busy;
    logic [EXC_CODE_LEN-1:0] exc;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int req_cnt;
    int busy_cnt;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [31:0] cap_wdata;
    logic [31:0] cap_addr;

    stage_memory dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .store_data  (store_data),
        .mem_op      (mem_op),
        .exc_in      (exc_in),
        .int_req     (int_req),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .load_result (load_result),
        .mem_busy    (mem_busy),
        .exc         (exc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Drives one access: op from cycle 0, ack pulse in cycle ack_at, op held through DONE.
    task automatic run_access(input logic [MEM_OP_LEN-1:0] op, input logic [31:0] a,
                              input logic [31:0] d, input int ack_at,
                              input logic [31:0] rd, input bit irq);
        req_cnt  = 0;
        busy_cnt = 0;
        for (int c = 0; c <= ack_at + 2; c++) begin
            @(posedge clk); #2;
            mem_op     = (c <= ack_at + 1) ? op : MEM_OP_NONE;
            addr       = a;
            store_data = d;
            int_req    = irq && (c >= 1) && (c <= ack_at + 1);
            bus_ack    = (c == ack_at);
            bus_rdata  = (c == ack_at) ? rd : 32'hCCCC_CCCC;
            #1;
            req_cnt  += int'(bus_req);
            busy_cnt += int'(mem_busy);
            if (c == 1) begin
                cap_be    = bus_be;
                cap_we    = bus_we;
                cap_wdata = bus_wdata;
                cap_addr  = bus_addr;
            end
        end
        mem_op  = MEM_OP_NONE;
        int_req = 1'b0;
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        total_cnt++; if ({bus_req, bus_we, bus_be} !== 6'b0) $display("FAIL reset_ctl: got %b want 000000", {bus_req, bus_we, bus_be}); else pass_cnt++;
        total_cnt++; if ({bus_addr, bus_wdata} !== 64'h0) $display("FAIL reset_bus: got %h want 0", {bus_addr, bus_wdata}); else pass_cnt++;
        total_cnt++; if (load_result !== 32'h0) $display("FAIL reset_load_result: got %h want 00000000", load_result); else pass_cnt++;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #3;
        total_cnt++; if ({bus_req, mem_busy, exc} !== 7'b0) $display("FAIL reset_release: got %b want 0", {bus_req, mem_busy, exc}); else pass_cnt++;
    endtask

    task automatic test_load_word();
        run_access(MEM_OP_LW, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        total_cnt++; if (req_cnt !== 3) $display("FAIL lw_req_cycles: got %0d want 3", req_cnt); else pass_cnt++;
        total_cnt++; if (busy_cnt !== 4) $display("FAIL lw_busy_cycles: got %0d want 4", busy_cnt); else pass_cnt++;
        total_cnt++; if (load_result !== 32'hDEAD_BEEF) $display("FAIL lw_result: got %h want deadbeef", load_result); else pass_cnt++;
        total_cnt++; if ({cap_addr, cap_be, cap_we} !== {32'h100, 4'b1111, 1'b0}) $display("FAIL lw_bus: got %h %b %b want 00000100 1111 0", cap_addr, cap_be, cap_we); else pass_cnt++;
    endtask

    task automatic test_stores();
        run_access(MEM_OP_SB, 32'h103, 32'h0000_005A, 1, 32'h0, 1'b0);
        total_cnt++; if ({cap_be, cap_we} !== {4'b1000, 1'b1}) $display("FAIL sb_be_we: got %b %b want 1000 1", cap_be, cap_we); else pass_cnt++;
        total_cnt++; if ({cap_wdata, cap_addr} !== {32'h5A5A_5A5A, 32'h100}) $display("FAIL sb_data_addr: got %h %h want 5a5a5a5a 00000100", cap_wdata, cap_addr); else pass_cnt++;
        total_cnt++; if (load_result !== 32'hDEAD_BEEF) $display("FAIL sb_keeps_result: got %h want deadbeef", load_result); else pass_cnt++;
        run_access(MEM_OP_SH, 32'h102, 32'hBEEF_1234, 2, 32'h0, 1'b0);
        total_cnt++; if ({cap_be, cap_wdata} !== {4'b1100, 32'h1234_1234}) $display("FAIL sh_lane: got %b %h want 1100 12341234", cap_be, cap_wdata); else pass_cnt++;
        run_access(MEM_OP_SW, 32'h104, 32'hCAFE_F00D, 1, 32'h0, 1'b0);
        total_cnt++; if ({cap_be, cap_wdata, cap_addr} !== {4'b1111, 32'hCAFE_F00D, 32'h104}) $display("FAIL sw_bus: got %b %h %h want 1111 cafef00d 00000104", cap_be, cap_wdata, cap_addr); else pass_cnt++;
    endtask

    task automatic test_load_extend();
        run_access(MEM_OP_LH, 32'h102, 32'h0, 1, 32'h8001_1234, 1'b0);
        total_cnt++; if (load_result !== 32'hFFFF_8001) $display("FAIL lh_sign: got %h want ffff8001", load_result); else pass_cnt++;
        total_cnt++; if ({req_cnt, busy_cnt} !== {32'd1, 32'd2}) $display("FAIL min_latency: got req %0d busy %0d want 1 2", req_cnt, busy_cnt); else pass_cnt++;
        run_access(MEM_OP_LHU, 32'h102, 32'h0, 1, 32'h8001_1234, 1'b0);
        total_cnt++; if (load_result !== 32'h0000_8001) $display("FAIL lhu_zero: got %h want 00008001", load_result); else pass_cnt++;
        run_access(MEM_OP_LB, 32'h101, 32'h0, 1, 32'h0000_8000, 1'b0);
        total_cnt++; if (load_result !== 32'hFFFF_FF80) $display("FAIL lb_sign: got %h want ffffff80", load_result); else pass_cnt++;
        run_access(MEM_OP_LBU, 32'h101, 32'h0, 1, 32'h0000_8000, 1'b0);
        total_cnt++; if (load_result !== 32'h0000_0080) $display("FAIL lbu_zero: got %h want 00000080", load_result); else pass_cnt++;
        run_access(MEM_OP_LH, 32'h100, 32'h0, 1, 32'h1234_7FFE, 1'b0);
        total_cnt++; if (load_result !== 32'h0000_7FFE) $display("FAIL lh_low_pos: got %h want 00007ffe", load_result); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        logic [MEM_OP_LEN-1:0]   ops  [4] = '{MEM_OP_LW, MEM_OP_SH, MEM_OP_SW, MEM_OP_LHU};
        logic [31:0]             adrs [4] = '{32'h101, 32'h101, 32'h102, 32'h103};
        logic [EXC_CODE_LEN-1:0] exps [4] = '{EXC_CODE_ADEL, EXC_CODE_ADES, EXC_CODE_ADES, EXC_CODE_ADEL};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            mem_op = ops[i];
            addr   = adrs[i];
            #1;
            total_cnt++; if ({exc, mem_busy} !== {exps[i], 1'b0}) $display("FAIL misaligned_%0d: got exc %0d busy %b want %0d 0", i, exc, mem_busy, exps[i]); else pass_cnt++;
            @(posedge clk); #3;
            total_cnt++; if (bus_req !== 1'b0) $display("FAIL misaligned_noreq_%0d: got %b want 0", i, bus_req); else pass_cnt++;
        end
        mem_op = MEM_OP_NONE;
    endtask

    task automatic test_exc_pass();
        @(posedge clk); #2;
        exc_in = 5'd3;
        mem_op = MEM_OP_LW;
        addr   = 32'h100;
        #1;
        total_cnt++; if ({exc, mem_busy} !== {5'd3, 1'b0}) $display("FAIL exc_pass: got %0d %b want 3 0", exc, mem_busy); else pass_cnt++;
        addr = 32'h101;
        #1;
        total_cnt++; if (exc !== 5'd3) $display("FAIL exc_pass_priority: got %0d want 3", exc); else pass_cnt++;
        @(posedge clk); #3;
        total_cnt++; if (bus_req !== 1'b0) $display("FAIL exc_pass_noreq: got %b want 0", bus_req); else pass_cnt++;
        exc_in = 5'd0;
        mem_op = MEM_OP_NONE;
    endtask

    task automatic test_interrupt();
        @(posedge clk); #2;
        int_req = 1'b1;
        mem_op  = MEM_OP_LW;
        addr    = 32'h100;
        #1;
        total_cnt++; if (mem_busy !== 1'b0) $display("FAIL int_blocks_busy: got %b want 0", mem_busy); else pass_cnt++;
        @(posedge clk); #3;
        total_cnt++; if (bus_req !== 1'b0) $display("FAIL int_blocks_req: got %b want 0", bus_req); else pass_cnt++;
        int_req = 1'b0;
        mem_op  = MEM_OP_NONE;
        run_access(MEM_OP_LW, 32'h200, 32'h0, 2, 32'h0BAD_F00D, 1'b1);
        total_cnt++; if ({req_cnt, load_result} !== {32'd2, 32'h0BAD_F00D}) $display("FAIL int_in_req: got req %0d res %h want 2 0badf00d", req_cnt, load_result); else pass_cnt++;
    endtask

    task automatic test_ack_outside();
        @(posedge clk); #2;
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_1111;
        @(posedge clk); #2;
        bus_ack = 1'b0;
        #1;
        total_cnt++; if ({bus_req, mem_busy, load_result} !== {2'b00, 32'h0BAD_F00D}) $display("FAIL ack_ignored: got %b %b %h want 0 0 0badf00d", bus_req, mem_busy, load_result); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #2;
        mem_op = MEM_OP_LW;
        addr   = 32'h300;
        @(posedge clk); #2;
        total_cnt++; if (bus_req !== 1'b1) $display("FAIL reset_mid_inreq: got %b want 1", bus_req); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if (bus_req !== 1'b0) $display("FAIL reset_mid_async: got %b want 0", bus_req); else pass_cnt++;
        mem_op    = MEM_OP_NONE;
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_7777;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #3;
        total_cnt++; if ({bus_req, mem_busy, load_result} !== {2'b00, 32'h0}) $display("FAIL reset_mid_nocompl: got %b %b %h want 0 0 00000000", bus_req, mem_busy, load_result); else pass_cnt++;
        bus_ack = 1'b0;
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int  dbe_cnt = 0;
        bit  done    = 1'b0;
        req_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            mem_op = done ? MEM_OP_NONE : MEM_OP_LW;
            addr   = 32'h100;
            #1;
            req_cnt += int'(bus_req);
            if (exc == EXC_CODE_DBE) dbe_cnt++;
            if (c > 0 && !mem_busy) done = 1'b1;
        end
        mem_op = MEM_OP_NONE;
        total_cnt++; if (req_cnt !== 15) $display("FAIL timeout_req_cycles: got %0d want 15", req_cnt); else pass_cnt++;
        total_cnt++; if (dbe_cnt !== 1) $display("FAIL timeout_dbe_cycles: got %0d want 1", dbe_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_load_word();
        test_stores();
        test_load_extend();
        test_misaligned();
        test_exc_pass();
        test_interrupt();
        test_ack_outside();
        test_reset_mid();
`ifdef MEM_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
